// File: rtl/count_sched.sv
`default_nettype none
// ============================================================================
// Module      : count_sched
// Description : Two-requester round-robin scheduler for one shared counter.
//               The granted requester's terminal count is latched at grant;
//               the counter then runs 0..TC on enabled cycles and the owner
//               receives a one-cycle DONE pulse on completion.
// Revision    : 1.0 - initial release
// ============================================================================
module count_sched #(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic             req0_i,
   input  logic [WIDTH-1:0] len0_i,
   input  logic             req1_i,
   input  logic [WIDTH-1:0] len1_i,
   output logic             gnt0_o,
   output logic             gnt1_o,
   output logic             busy_o,
   output logic [WIDTH-1:0] cnt_o,
   output logic             done0_o,
   output logic             done1_o
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN0 = 2'd1;
   localparam logic [1:0] S_RUN1 = 2'd2;

   localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] cnt_q,   cnt_d;
   logic [WIDTH-1:0] tc_q,    tc_d;
   logic             last_q,  last_d;
   logic             done0_q, done0_d;
   logic             done1_q, done1_d;

   // Next-state logic: arbitration in IDLE, counting/abort/completion in RUNx.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tc_d    = tc_q;
      last_d  = last_q;
      done0_d = 1'b0;
      done1_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            // Requester 0 wins when alone, or when both ask and 1 was served last.
            if (req0_i && (!req1_i || last_q)) begin
               state_d = S_RUN0;
               tc_d    = len0_i;
               cnt_d   = CNT_ZERO;
               last_d  = 1'b0;
            end else if (req1_i) begin
               state_d = S_RUN1;
               tc_d    = len1_i;
               cnt_d   = CNT_ZERO;
               last_d  = 1'b1;
            end
         end

         S_RUN0: begin
            // Abort is checked first so it overrides a same-cycle completion.
            if (!req0_i) begin
               state_d = S_IDLE;
               cnt_d   = CNT_ZERO;
            end else if (en_i) begin
               if (cnt_q == tc_q) begin
                  state_d = S_IDLE;
                  cnt_d   = CNT_ZERO;
                  done0_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
         end

         S_RUN1: begin
            if (!req1_i) begin
               state_d = S_IDLE;
               cnt_d   = CNT_ZERO;
            end else if (en_i) begin
               if (cnt_q == tc_q) begin
                  state_d = S_IDLE;
                  cnt_d   = CNT_ZERO;
                  done1_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
         end

         default: begin
            state_d = S_IDLE;
            cnt_d   = CNT_ZERO;
         end
      endcase
   end

   // State registers with asynchronous reset; LAST resets to 1 so 0 wins first tie.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= CNT_ZERO;
         tc_q    <= CNT_ZERO;
         last_q  <= 1'b1;
         done0_q <= 1'b0;
         done1_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tc_q    <= tc_d;
         last_q  <= last_d;
         done0_q <= done0_d;
         done1_q <= done1_d;
      end
   end

   assign gnt0_o  = (state_q == S_RUN0);
   assign gnt1_o  = (state_q == S_RUN1);
   assign busy_o  = (state_q != S_IDLE);
   assign cnt_o   = cnt_q;
   assign done0_o = done0_q;
   assign done1_o = done1_q;

endmodule
`default_nettype wire

// File: tb/tb_count_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_count_sched
// Description : Scoreboard bench for count_sched. A run-level reference model
//               predicts the outputs after every edge; a monitor compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_count_sched;
   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             en = 1'b0;
   logic             req0 = 1'b0;
   logic             req1 = 1'b0;
   logic [WIDTH-1:0] len0 = '0;
   logic [WIDTH-1:0] len1 = '0;
   logic             gnt0, gnt1, busy, done0, done1;
   logic [WIDTH-1:0] cnt;

   count_sched #(.WIDTH(WIDTH)) dut (
      .clk_i  (clk),
      .rst_i  (rst),
      .en_i   (en),
      .req0_i (req0),
      .len0_i (len0),
      .req1_i (req1),
      .len1_i (len1),
      .gnt0_o (gnt0),
      .gnt1_o (gnt1),
      .busy_o (busy),
      .cnt_o  (cnt),
      .done0_o(done0),
      .done1_o(done1)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic             gnt0;
      logic             gnt1;
      logic             busy;
      logic             done0;
      logic             done1;
      logic [WIDTH-1:0] cnt;
   } obs_t;

   obs_t sb[$];
   int   tests = 0;
   int   fails = 0;

   // Run-level model: who owns the counter, how many enabled cycles it has
   // consumed, and its latched terminal count. A run ends after TC+1 of them.
   int m_own  = -1;
   int m_el   = 0;
   int m_tc   = 0;
   int m_last = 1;
   bit m_d0   = 1'b0;
   bit m_d1   = 1'b0;

   function automatic obs_t model_out();
      obs_t o;
      o.gnt0  = (m_own == 0);
      o.gnt1  = (m_own == 1);
      o.busy  = (m_own >= 0);
      o.done0 = m_d0;
      o.done1 = m_d1;
      o.cnt   = (m_own >= 0) ? WIDTH'(m_el) : '0;
      return o;
   endfunction

   task automatic model_step();
      int pick;
      bit myreq;
      if (rst) begin
         m_own = -1; m_el = 0; m_tc = 0; m_last = 1; m_d0 = 0; m_d1 = 0;
      end else if (m_own < 0) begin
         m_d0 = 0; m_d1 = 0;
         pick = -1;
         if (req0 && req1) pick = 1 - m_last;
         else if (req0)    pick = 0;
         else if (req1)    pick = 1;
         if (pick >= 0) begin
            m_own  = pick;
            m_tc   = (pick == 0) ? int'(len0) : int'(len1);
            m_el   = 0;
            m_last = pick;
         end
      end else begin
         myreq = (m_own == 0) ? req0 : req1;
         if (!myreq) begin
            m_own = -1;
         end else if (en) begin
            m_el++;
            if (m_el == m_tc + 1) begin
               if (m_own == 0) m_d0 = 1; else m_d1 = 1;
               m_own = -1;
            end
         end
      end
   endtask

   task automatic drive(input bit r, input bit q0, input logic [WIDTH-1:0] l0,
                        input bit q1, input logic [WIDTH-1:0] l1, input bit e);
      @(negedge clk);
      rst = r; req0 = q0; len0 = l0; req1 = q1; len1 = l1; en = e;
      model_step();
      sb.push_back(model_out());
   endtask

   // Monitor: after every rising edge, compare against the oldest prediction.
   initial begin
      obs_t exp_o, got;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() != 0) begin
            exp_o = sb.pop_front();
            got   = '{gnt0, gnt1, busy, done0, done1, cnt};
            tests++;
            if (got !== exp_o) begin
               fails++;
               $display("FAIL outputs t=%0t got gnt0=%b gnt1=%b busy=%b done0=%b done1=%b cnt=%0d exp gnt0=%b gnt1=%b busy=%b done0=%b done1=%b cnt=%0d",
                        $time, got.gnt0, got.gnt1, got.busy, got.done0, got.done1, got.cnt,
                        exp_o.gnt0, exp_o.gnt1, exp_o.busy, exp_o.done0, exp_o.done1, exp_o.cnt);
            end
         end
      end
   end

   function automatic logic [WIDTH-1:0] rand_len();
      if ($urandom_range(15) == 0) return WIDTH'($urandom_range(20, 40));
      return WIDTH'($urandom_range(0, 12));
   endfunction

   initial begin
      bit               rq0, rq1, e;
      logic [WIDTH-1:0] ln0, ln1;
      bit               hold;

      // Reset held for two edges.
      drive(1, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0);

      // Single requester, LEN0=3.
      for (int i = 0; i < 10; i++) drive(0, 1, 3, 0, 0, 1);
      drive(0, 0, 0, 0, 0, 1);
      drive(0, 0, 0, 0, 0, 1);

      // Fresh reset, then a tie: 0 first, then 1 after an IDLE cycle.
      drive(1, 0, 0, 0, 0, 1);
      hold = 1'b1;
      for (int i = 0; i < 14; i++) begin
         drive(0, hold, 2, 1, 1, 1);
         if (m_d0) hold = 1'b0;
         if (m_d1) break;
      end
      drive(0, 0, 0, 0, 0, 1);
      drive(0, 0, 0, 0, 0, 1);

      // Pause at CNT=2 for three cycles with LEN0=5.
      for (int i = 0; i < 20; i++) begin
         drive(0, 1, 5, 0, 0, !(i >= 3 && i < 6));
         if (m_d0) break;
      end
      drive(0, 0, 0, 0, 0, 1);

      // Full-range run without wrap, LEN1=255; LEN1 disturbed after grant.
      for (int i = 0; i < 300; i++) begin
         drive(0, 0, 0, 1, (i < 2) ? 8'd255 : WIDTH'($urandom), 1);
         if (m_d1) break;
      end
      drive(0, 0, 0, 0, 0, 1);

      // Abort: REQ1 drops at CNT=4 with LEN1=10.
      for (int i = 0; i < 5; i++) drive(0, 0, 0, 1, 10, 1);
      for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 10, 1);

      // Asynchronous reset mid-run at CNT=7.
      for (int i = 0; i < 8; i++) drive(0, 1, 20, 0, 0, 1);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      tests++;
      if ({gnt0, gnt1, busy, done0, done1, cnt} !== '0) begin
         fails++;
         $display("FAIL async_reset got gnt0=%b gnt1=%b busy=%b done0=%b done1=%b cnt=%0d exp all 0",
                  gnt0, gnt1, busy, done0, done1, cnt);
      end
      model_step();
      sb.push_back(model_out());
      drive(1, 1, 4, 1, 2, 1);
      for (int i = 0; i < 12; i++) drive(0, 1, 4, 1, 2, 1);

      // Randomized traffic.
      rq0 = 0; rq1 = 0; ln0 = 0; ln1 = 0;
      drive(0, 0, 0, 0, 0, 1);
      for (int c = 0; c < 1500; c++) begin
         if (!rq0) begin
            if ($urandom_range(3) == 0) begin rq0 = 1; ln0 = rand_len(); end
         end else if (m_d0) begin
            if ($urandom_range(1) == 0) rq0 = 0;
         end else if (m_own == 0) begin
            if ($urandom_range(29) == 0) rq0 = 0;
            if ($urandom_range(7) == 0) ln0 = WIDTH'($urandom);
         end
         if (!rq1) begin
            if ($urandom_range(3) == 0) begin rq1 = 1; ln1 = rand_len(); end
         end else if (m_d1) begin
            if ($urandom_range(1) == 0) rq1 = 0;
         end else if (m_own == 1) begin
            if ($urandom_range(29) == 0) rq1 = 0;
            if ($urandom_range(7) == 0) ln1 = WIDTH'($urandom);
         end
         e = ($urandom_range(4) != 0);
         drive(0, rq0, ln0, rq1, ln1, e);
      end

      @(posedge clk);
      #3;
      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL drain got %0d pending exp 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
